// File: rtl/gel_serial_compare_if.sv
// Operand/result bundle for the bit-serial GEL comparator: the master issues start with A/B,
// the slave returns busy, a one-cycle done pulse, and the one-hot GEL result.
interface gel_serial_compare_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       GEL;
  logic             busy;
  logic             done;

  modport master (
    output start,
    output A,
    output B,
    input  GEL,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  A,
    input  B,
    output GEL,
    output busy,
    output done
  );
endinterface

// File: rtl/gel_serial_compare.sv
// Bit-serial MSB-first magnitude compare producing one-hot GEL; done 2..WIDTH+1 cycles after start.
// start is ignored while busy; SIGNED_CMP_EN selects two's-complement operands.
module gel_serial_compare #(
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 reset,
  gel_serial_compare_if.slave cmp
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [2:0] GEL_GT   = 3'b100;
  localparam logic [2:0] GEL_EQ   = 3'b010;
  localparam logic [2:0] GEL_LT   = 3'b001;
  localparam logic [2:0] GEL_NONE = 3'b000;

  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = '0;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [2:0]       gel_r;

  logic a_bit;
  logic b_bit;
  logic bits_differ;
  logic a_wins;

  always_comb begin
    a_bit       = a_r[idx];
    b_bit       = b_r[idx];
    bits_differ = a_bit ^ b_bit;
`ifdef SIGNED_CMP_EN
    // The sign bit carries negative weight, so a set bit there means the smaller operand.
    a_wins      = (idx == IDX_MSB) ? b_bit : a_bit;
`else
    a_wins      = a_bit;
`endif
  end

  // Operands are captured only on an accepted start; they need no reset.
  always_ff @(posedge clk) begin
    if (!reset && (state == ST_IDLE) && cmp.start) begin
      a_r <= cmp.A;
      b_r <= cmp.B;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      idx   <= IDX_ZERO;
      gel_r <= GEL_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmp.start) begin
            idx   <= IDX_MSB;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bits_differ) begin
            gel_r <= a_wins ? GEL_GT : GEL_LT;
            state <= ST_DONE;
          end else if (idx == IDX_ZERO) begin
            gel_r <= GEL_EQ;
            state <= ST_DONE;
          end else begin
            idx <= idx - IDX_ONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmp.GEL  = gel_r;
  assign cmp.busy = (state != ST_IDLE);
  assign cmp.done = (state == ST_DONE);

  gel_onehot_chk: assert property (@(posedge clk) $onehot0(gel_r));

endmodule

// File: tb/tb_gel_serial_compare.sv
// Self-checking bench for gel_serial_compare: vector table, directed multi-cycle cases, random vs. model.
module tb_gel_serial_compare;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  gel_serial_compare_if #(.WIDTH(WIDTH)) bus ();

  gel_serial_compare #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .cmp   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] gel;
    int         cycles;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer comparison, latency from the highest differing bit.
  function automatic logic [2:0] ref_gel(input logic [7:0] a, input logic [7:0] b);
    int sa;
    int sb;
`ifdef SIGNED_CMP_EN
    sa = int'($signed(a));
    sb = int'($signed(b));
`else
    sa = int'(a);
    sb = int'(b);
`endif
    if (sa > sb) return 3'b100;
    if (sa < sb) return 3'b001;
    return 3'b010;
  endfunction

  function automatic int ref_cycles(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x;
    int d;
    x = a ^ b;
    d = WIDTH - 1;
    for (int i = 0; i < WIDTH; i++) begin
      if (x[i]) d = WIDTH - 1 - i;
    end
    return 2 + d;
  endfunction

  task automatic run_cmp(input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] eg, input int ec, input string nm);
    logic [2:0] prev;
    int cyc;
    prev      = bus.GEL;
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    step();
    bus.start = 1'b0;
    bus.A     = 8'($urandom);
    bus.B     = 8'($urandom);
    cyc = 1;
    while (!bus.done && cyc < WIDTH + 4) begin
      check({nm, " busy_run"}, int'(bus.busy), 1);
      check({nm, " gel_hold"}, int'(bus.GEL), int'(prev));
      step();
      cyc++;
    end
    check({nm, " latency"}, cyc, ec);
    check({nm, " gel"}, int'(bus.GEL), int'(eg));
    check({nm, " busy_done"}, int'(bus.busy), 1);
    step();
    check({nm, " done_clear"}, int'(bus.done), 0);
    check({nm, " idle"}, int'(bus.busy), 0);
    check({nm, " gel_keep"}, int'(bus.GEL), int'(eg));
  endtask

  initial begin
    int cyc;
    int n_done;
    logic [7:0] ra;
    logic [7:0] rb;

`ifdef SIGNED_CMP_EN
    vecs[0] = '{8'h80, 8'h7F, 3'b001, 2};
    vecs[5] = '{8'h00, 8'hFF, 3'b100, 2};
`else
    vecs[0] = '{8'h80, 8'h7F, 3'b100, 2};
    vecs[5] = '{8'h00, 8'hFF, 3'b001, 2};
`endif
    vecs[1] = '{8'h5A, 8'h5A, 3'b010, 9};
    vecs[2] = '{8'h12, 8'h13, 3'b001, 9};
    vecs[3] = '{8'h03, 8'h02, 3'b100, 9};
    vecs[4] = '{8'h40, 8'h20, 3'b100, 3};

    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    reset     = 1'b1;
    step();
    step();
    check("reset gel", int'(bus.GEL), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    reset = 1'b0;
    step();
    check("idle no_start busy", int'(bus.busy), 0);

    for (int i = 0; i < 6; i++) begin
      run_cmp(vecs[i].a, vecs[i].b, vecs[i].gel, vecs[i].cycles, $sformatf("vec%0d", i));
    end

    // A second start while busy must be dropped.
    bus.start = 1'b1; bus.A = 8'h00; bus.B = 8'h01;
    step();
    bus.A = 8'hFF; bus.B = 8'h00;
    step();
    bus.start = 1'b0;
    cyc = 2;
    while (!bus.done && cyc < WIDTH + 4) begin
      step();
      cyc++;
    end
    check("ignore latency", cyc, 9);
    check("ignore gel", int'(bus.GEL), 1);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.done) n_done++;
    end
    check("ignore extra_done", n_done, 0);
    check("ignore gel_hold", int'(bus.GEL), 1);

    // start held high: d=0 gives a result every 3 cycles.
    bus.start = 1'b1; bus.A = 8'h80; bus.B = 8'h7F;
    step();
    for (int c = 1; c <= 9; c++) begin
      check($sformatf("stream done c%0d", c), int'(bus.done), int'(c % 3 == 2));
      step();
    end
    bus.start = 1'b0;
    step(); step(); step();
    check("stream gel", int'(bus.GEL), int'(ref_gel(8'h80, 8'h7F)));
    check("stream idle", int'(bus.busy), 0);

    // Reset in the 4th RUN cycle aborts without a done pulse.
    bus.start = 1'b1; bus.A = 8'h00; bus.B = 8'h00;
    step();
    bus.start = 1'b0;
    step(); step(); step();
    check("abort busy_before", int'(bus.busy), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort gel", int'(bus.GEL), 0);
    check("abort busy", int'(bus.busy), 0);
    check("abort done", int'(bus.done), 0);
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.done || bus.busy) n_done++;
    end
    check("abort quiet", n_done, 0);
    run_cmp(8'h03, 8'h02, 3'b100, 9, "after_abort");

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      case ($urandom_range(0, 2))
        0: rb = ra;
        1: rb = ra ^ (8'h01 << $urandom_range(0, 7));
        default: rb = 8'($urandom);
      endcase
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) step();
      end
      run_cmp(ra, rb, ref_gel(ra, rb), ref_cycles(ra, rb), $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
